// File: rtl/rat_int_ctrl.sv
// rat_int_ctrl -- interrupt controller for the RAT MCU.
//
// Captures rising edges on up to N_SRC asynchronous interrupt lines into
// per-source pending bits. It then picks the lowest-index pending, unmasked
// source and hands it to the control unit at an instruction boundary. It also
// sequences the C/Z flag shadow registers and owns the global interrupt-enable
// (I) flag.
//
// Ports:
//   clk          system clock, rising edge
//   RST          asynchronous active-high reset
//   INT_SRC      raw interrupt lines (asynchronous, rising-edge significant)
//   INT_MASK     per-source enable, 1 = enabled
//   I_SET        SEI executed (1-cycle pulse)
//   I_CLR        CLI executed (1-cycle pulse)
//   FETCH_BND    CU is at an instruction boundary this cycle
//   RETIE        RETIE executed (1-cycle pulse)
//   INT_TAKE     1-cycle pulse, CU enters its interrupt cycle
//   INT_VEC      ISR address, valid with INT_TAKE and held through the ISR
//   FLG_SHAD_LD  1-cycle pulse, shadow C/Z load current flags
//   FLG_RESTORE  1-cycle pulse, C/Z reload from shadows
//   I_FLAG       global interrupt enable
//   IN_ISR       high from the TAKE cycle through the RETIE cycle
//   PENDING      pending bits, for status/debug
module rat_int_ctrl #(
    parameter int         N_SRC    = 4,
    parameter logic [9:0] VEC_BASE = 10'h3F8
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_SRC-1:0] INT_SRC,
    input  logic [N_SRC-1:0] INT_MASK,
    input  logic             I_SET,
    input  logic             I_CLR,
    input  logic             FETCH_BND,
    input  logic             RETIE,
    output logic             INT_TAKE,
    output logic [9:0]       INT_VEC,
    output logic             FLG_SHAD_LD,
    output logic             FLG_RESTORE,
    output logic             I_FLAG,
    output logic             IN_ISR,
    output logic [N_SRC-1:0] PENDING
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_ISR  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [N_SRC-1:0] sync1_reg, sync2_reg, dly_reg;
    logic [N_SRC-1:0] pending_reg, pending_next;
    logic [N_SRC-1:0] take_mask_reg;
    logic [N_SRC-1:0] rise, eligible, winner_onehot;
    logic [IDX_W-1:0] winner_idx;
    logic [9:0]       vec_reg;
    logic             i_flag_reg;
    logic             take_go;
    logic             retie_in_isr;
    logic             in_take;

    assign in_take = (state_reg == ST_TAKE);

    // Per-source capture: 2-FF synchronizer, edge-detect delay FF and the
    // pending bit. A fresh edge in the same cycle as the clear keeps the bit
    // set, so a re-trigger of the source being taken is not lost.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                    dly_reg[gi]   <= 1'b0;
                end else begin
                    sync1_reg[gi] <= INT_SRC[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                    dly_reg[gi]   <= sync2_reg[gi];
                end
            end

            assign rise[gi]         = sync2_reg[gi] & ~dly_reg[gi];
            assign pending_next[gi] = rise[gi] |
                                      (pending_reg[gi] & ~(in_take & take_mask_reg[gi]));

            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    pending_reg[gi] <= 1'b0;
                end else begin
                    pending_reg[gi] <= pending_next[gi];
                end
            end
        end
    endgenerate

    // Fixed priority: lowest index wins. The one-hot form isolates the lowest
    // set bit and is kept to clear exactly that pending bit during TAKE.
    assign eligible      = pending_reg & INT_MASK;
    assign winner_onehot = eligible & (~eligible + N_SRC'(1));

    always_comb begin
        winner_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner_idx = IDX_W'(i);
            end
        end
    end

    assign take_go      = (state_reg == ST_IDLE) && i_flag_reg && (|eligible) && FETCH_BND;
    assign retie_in_isr = (state_reg == ST_ISR) && RETIE;

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and output decode
    always_comb begin
        state_next  = state_reg;
        INT_TAKE    = 1'b0;
        FLG_SHAD_LD = 1'b0;
        FLG_RESTORE = 1'b0;
        IN_ISR      = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (take_go) begin
                    state_next = ST_TAKE;
                end
            end
            ST_TAKE: begin
                INT_TAKE    = 1'b1;
                FLG_SHAD_LD = 1'b1;
                IN_ISR      = 1'b1;
                state_next  = ST_ISR;
            end
            ST_ISR: begin
                IN_ISR = 1'b1;
                if (RETIE) begin
                    FLG_RESTORE = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Winner latch: vector and clear mask are captured on the take decision
    // and held for the whole ISR.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            vec_reg       <= '0;
            take_mask_reg <= '0;
        end else if (take_go) begin
            vec_reg       <= VEC_BASE + {{(10 - IDX_W){1'b0}}, winner_idx};
            take_mask_reg <= winner_onehot;
        end
    end

    // Global interrupt enable. TAKE forces it low regardless of SEI; outside
    // TAKE, CLI beats SEI and RETIE.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            i_flag_reg <= 1'b0;
        end else if (in_take) begin
            i_flag_reg <= 1'b0;
        end else if (I_CLR) begin
            i_flag_reg <= 1'b0;
        end else if (I_SET || retie_in_isr) begin
            i_flag_reg <= 1'b1;
        end
    end

    assign INT_VEC = vec_reg;
    assign I_FLAG  = i_flag_reg;
    assign PENDING = pending_reg;

endmodule
